if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch prefetcher with a DEPTH-entry instruction buffer.
// A single memory request is kept outstanding at a time. Redirects flush the
// buffer. A request already in flight when a redirect arrives is allowed to
// finish, and its data is dropped.
// Optional build macro IF_PREFETCH_PERF_EN adds the stall_cycles counter output.
module if_prefetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [63:0] if_pc,
   input  logic        if_ready
`ifdef IF_PREFETCH_PERF_EN
  ,output logic [31:0] stall_cycles
`endif
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = AW + 1;
   localparam logic [63:0] RESET_PC_AL = {RESET_PC[63:2], 2'b00};

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
   } ibuf_entry_t;

   state_t              state, state_nxt;
   logic [63:0]         fetch_pc, fetch_pc_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [AW-1:0]       rd_ptr, wr_ptr;
   ibuf_entry_t         ibuf [DEPTH];
   logic                push, pop, issue, space_ok;

   // Buffer handshakes; a redirect kills both the incoming data and any pop.
   always_comb begin
      push = (state == WAIT) && imem_ack && !redirect_valid;
      pop  = if_valid && if_ready && !redirect_valid;
   end

   // Next occupancy, and whether one more request can be launched against it.
   always_comb begin
      cnt_nxt = cnt;
      if (redirect_valid)
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);
      space_ok = (cnt_nxt < CNT_W'(DEPTH));
   end

   // Next fetch PC: redirect target wins, otherwise advance past an accepted word.
   always_comb begin
      fetch_pc_nxt = fetch_pc;
      if (redirect_valid)
         fetch_pc_nxt = {redirect_pc[63:2], 2'b00};
      else if (push)
         fetch_pc_nxt = fetch_pc + 64'd4;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state. IDLE waits out a redirect cycle, so the new fetch_pc is in place before issuing.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!redirect_valid && space_ok) state_nxt = WAIT;
         end
         WAIT: begin
            if (redirect_valid)
               state_nxt = imem_ack ? IDLE : DRAIN;
            else if (imem_ack)
               state_nxt = space_ok ? WAIT : IDLE;
         end
         DRAIN: begin
            if (imem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: the request stays high for the whole WAIT or DRAIN span; a new address is latched only on issue.
   always_comb begin
      imem_req = (state != IDLE);
      issue    = (state_nxt == WAIT) && ((state == IDLE) || imem_ack);
   end

   // Fetch PC and the request address register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc  <= RESET_PC_AL;
         imem_addr <= RESET_PC_AL;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         if (issue) imem_addr <= fetch_pc_nxt;
      end
   end

   // Circular-buffer pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Buffer storage. It is cleared on reset so that the head reads as zero afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ibuf[i] <= '0;
      end else if (push) begin
         ibuf[wr_ptr] <= '{instr: imem_rdata, pc: fetch_pc};
      end
   end

   // Head presentation, read directly from the registered storage.
   always_comb begin
      if_valid = (cnt != '0);
      if_instr = ibuf[rd_ptr].instr;
      if_pc    = ibuf[rd_ptr].pc;
   end

`ifdef IF_PREFETCH_PERF_EN
   // Count cycles where the datapath is ready but no instruction is available; the count saturates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cycles <= '0;
      else if (if_ready && !if_valid && (stall_cycles != 32'hFFFF_FFFF))
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule
